// File: rtl/seven_seg_scanner_pkg.sv
// Shared constants for the 7-segment scanner: segment vector width and the
// active-low segment patterns, ordered {g,f,e,d,c,b,a}.
package seven_seg_scanner_pkg;

  localparam int unsigned SegWidth = 7;

  localparam logic [SegWidth-1:0] SegOff  = 7'h7F;
  localparam logic [SegWidth-1:0] SegDash = 7'b0111111;

  localparam logic [SegWidth-1:0] SegZero  = 7'b1000000;
  localparam logic [SegWidth-1:0] SegOne   = 7'b1111001;
  localparam logic [SegWidth-1:0] SegTwo   = 7'b0100100;
  localparam logic [SegWidth-1:0] SegThree = 7'b0110000;
  localparam logic [SegWidth-1:0] SegFour  = 7'b0011001;
  localparam logic [SegWidth-1:0] SegFive  = 7'b0010010;
  localparam logic [SegWidth-1:0] SegSix   = 7'b0000010;
  localparam logic [SegWidth-1:0] SegSeven = 7'b1111000;
  localparam logic [SegWidth-1:0] SegEight = 7'b0000000;
  localparam logic [SegWidth-1:0] SegNine  = 7'b0010000;

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational digit-code to active-low segment decoder; codes >= 10 show a dash.
module seven_seg_decoder
  import seven_seg_scanner_pkg::*;
#(
  parameter int unsigned NUMBER_OF_BITS = 4
) (
  input  logic [NUMBER_OF_BITS-1:0] code,
  output logic [SegWidth-1:0]       segments
);

  // Map the zero-extended code so any digit width decodes the same way
  always_comb begin
    segments = SegDash;
    case (32'(code))
      32'd0:   segments = SegZero;
      32'd1:   segments = SegOne;
      32'd2:   segments = SegTwo;
      32'd3:   segments = SegThree;
      32'd4:   segments = SegFour;
      32'd5:   segments = SegFive;
      32'd6:   segments = SegSix;
      32'd7:   segments = SegSeven;
      32'd8:   segments = SegEight;
      32'd9:   segments = SegNine;
      default: segments = SegDash;
    endcase
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode 7-segment scanner. Digits are captured once per
// frame, each slot starts with a blanking window, and leading zeros can be hidden.
module seven_seg_scanner
  import seven_seg_scanner_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned NUMBER_OF_BITS = 4,
  parameter int unsigned REFRESH_DIV    = 100000,
  parameter int unsigned BLANK_CYCLES   = 1000,
  parameter int unsigned LZ_BLANK       = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               enable,
  input  logic [NUM_DIGITS*NUMBER_OF_BITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]              dp_in,
  output logic [NUM_DIGITS-1:0]              anode,
  output logic [SegWidth-1:0]                segments,
  output logic                               dp_out,
  output logic                               frame_tick
);

  localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned DW = NUM_DIGITS * NUMBER_OF_BITS;

  logic [PW-1:0]             p_q, p_d;
  logic [SW-1:0]             s_q, s_d;
  logic [DW-1:0]             snap_digits_q;
  logic [NUM_DIGITS-1:0]     snap_dp_q;
  logic                      snap_load;

  logic [NUM_DIGITS-1:0]     anode_d;
  logic [SegWidth-1:0]       segments_d;
  logic                      dp_d;
  logic                      tick_d;

  logic [NUMBER_OF_BITS-1:0] cur_digit;
  logic [SegWidth-1:0]       dec_segments;
  logic [NUM_DIGITS-1:0]     zero_from;
  logic                      zero_acc;
  logic                      blank;
  logic                      suppress;

  // Prescaler/slot advance; disabled scanning parks at slot 0 with a live snapshot
  always_comb begin
    p_d       = p_q;
    s_d       = s_q;
    snap_load = 1'b0;
    if (!enable) begin
      p_d       = '0;
      s_d       = '0;
      snap_load = 1'b1;
    end else if (p_q == PW'(REFRESH_DIV - 1)) begin
      p_d = '0;
      if (s_q == SW'(NUM_DIGITS - 1)) begin
        s_d       = '0;
        snap_load = 1'b1;
      end else begin
        s_d = s_q + 1'b1;
      end
    end else begin
      p_d = p_q + 1'b1;
    end
  end

  // Scan state and frame-coherent snapshot
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_q           <= '0;
      s_q           <= '0;
      snap_digits_q <= '0;
      snap_dp_q     <= '0;
    end else begin
      p_q <= p_d;
      s_q <= s_d;
      if (snap_load) begin
        snap_digits_q <= digits;
        snap_dp_q     <= dp_in;
      end
    end
  end

  assign cur_digit = snap_digits_q[s_q*NUMBER_OF_BITS +: NUMBER_OF_BITS];

  seven_seg_decoder #(
    .NUMBER_OF_BITS(NUMBER_OF_BITS)
  ) u_decoder (
    .code    (cur_digit),
    .segments(dec_segments)
  );

  // zero_from[k] is set when snapshot digits k..NUM_DIGITS-1 are all zero
  always_comb begin
    zero_acc  = 1'b1;
    zero_from = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_acc     = zero_acc & (snap_digits_q[k*NUMBER_OF_BITS +: NUMBER_OF_BITS] == '0);
      zero_from[k] = zero_acc;
    end
  end

  assign blank    = 32'(p_q) < BLANK_CYCLES;
  assign suppress = (LZ_BLANK != 0) && (s_q != '0) && zero_from[s_q];

  // Next output values from the current scan state
  always_comb begin
    anode_d    = '1;
    segments_d = SegOff;
    dp_d       = 1'b1;
    tick_d     = 1'b0;
    if (enable) begin
      tick_d = (p_q == '0) && (s_q == '0);
      if (!blank && !suppress) begin
        anode_d    = ~(NUM_DIGITS'(1) << s_q);
        segments_d = dec_segments;
        dp_d       = ~snap_dp_q[s_q];
      end
    end
  end

  // Registered outputs, one cycle behind the scan state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      anode      <= '1;
      segments   <= SegOff;
      dp_out     <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      anode      <= anode_d;
      segments   <= segments_d;
      dp_out     <= dp_d;
      frame_tick <= tick_d;
    end
  end

endmodule
